three_input_and_gate_b: RTL and testbench
=========================================

# three_input_and_gate_b

Registered three-input AND block with an exposed two-input intermediate term. Inputs A, B, C are asynchronous relative to the system clock. They are synchronized, then combined into D = A&B and E = A&B&C, both registered. A saturating count of E rising edges is also provided. The block sits at the boundary between free-running level stimuli and synchronous logic.

## Interface
- SYNC_STAGES, 2, synchronizer flops per input (legal 0..4; 0 = no synchronizer, inputs sampled directly by the logic register)
- COUNT_W, 8, width of e_count
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous active-high reset
- A  input  1  asynchronous level input
- B  input  1  asynchronous level input
- C  input  1  asynchronous level input
- D  output  1  registered A&B (synchronized values)
- E  output  1  registered A&B&C (synchronized values); equals D&C_sync
- e_rise  output  1  one-cycle pulse when E transitions 0->1
- e_count  output  COUNT_W  saturating count of E rising edges

## Operation
- Each of A, B, C passes through its own SYNC_STAGES-deep flop chain. Resulting signals are As, Bs, Cs.
- Logic register on each clk edge:
  - D <= As & Bs
  - E <= As & Bs & Cs
- E is always a subset of D. D=0 implies E=0 in every cycle, including transients.
- e_rise <= E_next & ~E, evaluated at the same edge E updates. e_rise is therefore high in the cycle E first reads 1.
- e_count increments by 1 on each cycle e_rise is 1.
  - Saturates at 2^COUNT_W-1 and never wraps.
  - Cleared only by rst.
- No other state. No enable, no handshake.
- rst=1 at a clk edge clears to 0:
  - all synchronizer flops
  - D, E, e_rise, e_count
- rst has priority over all updates. Reset mid-operation discards in-flight synchronizer contents.
- While rst is held high, outputs stay 0 regardless of inputs.

## Timing
- Reset values: D=0, E=0, e_rise=0, e_count=0.
- Latency from an input change (settled before clk edge n) to D/E update: SYNC_STAGES+1 clock edges. Default is 3 cycles.
- Inputs changing within setup/hold of a clk edge may be captured one cycle late. Latency is SYNC_STAGES+1 or SYNC_STAGES+2 cycles, never other.
- Simultaneous input changes in the same cycle take effect at the same output edge. There is no intermediate glitch value unless they straddle a sampling edge.
- e_rise asserts in the same cycle E first becomes 1 and lasts exactly one cycle.
- e_count reflects the increment one cycle after e_rise is visible, i.e. it is registered from e_rise.
- After rst deasserts, first valid D/E is SYNC_STAGES+1 edges after the first post-reset sample.

## Test plan
- Reset: drive A=B=C=1, rst=1 for 4 cycles -> D=0, E=0, e_rise=0, e_count=0 throughout. Release rst -> D=1, E=1 after 3 edges; e_rise=1 for one cycle; e_count=1 next cycle.
- Truth table: step {A,B,C} through all 8 combinations, holding each 10 cycles -> D=1 only for A=B=1; E=1 only for 111. Verify D&~E=1 only for 110. Each update occurs 3 cycles after the input change.
- Asynchronous toggling:
  - stimulus: A, B, C toggle with half-periods 100, 70, 50 ns against a 10 ns clock for 2000 ns
  - required: D/E match the reference AND of inputs delayed 3–4 cycles
  - required: E never 1 while D is 0
  - required: e_count equals the number of E rising edges
- Saturation: with COUNT_W=2, generate 6 E pulses (C toggling with A=B=1) -> e_count reads 1,2,3,3,3,3. e_rise still pulses each time.
- Reset mid-operation: A=B=C=1 at cycle 0, rst=1 at cycle 2 for 1 cycle -> D/E stay 0 until 3 edges after release. e_count counts 1 edge, not 2.
- SYNC_STAGES=0 build: input change before edge n -> D/E update at edge n (1-cycle latency), truth table identical.

Source files
------------

// File: rtl/three_input_and_gate_b.sv
// three_input_and_gate_b: synchronized, registered three-input AND with E rise pulse and saturating rise counter
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset, clears every flop
//   A, B, C  asynchronous level inputs
//   D        registered As & Bs
//   E        registered As & Bs & Cs, always a subset of D
//   e_rise   one-cycle pulse in the first cycle E reads 1
//   e_count  saturating count of e_rise pulses, one cycle behind e_rise
module three_input_and_gate_b #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               A,
    input  logic               B,
    input  logic               C,
    output logic               D,
    output logic               E,
    output logic               e_rise,
    output logic [COUNT_W-1:0] e_count
);
    logic [2:0] abc_s;
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign abc_s = {A, B, C};
        end else begin : g_sync
            logic [2:0] sync_q [SYNC_STAGES];
            logic [2:0] sync_d [SYNC_STAGES];
            always_comb begin
                sync_d[0] = {A, B, C};
                for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
            end
            always_ff @(posedge clk) begin
                for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= rst ? 3'b000 : sync_d[i];
            end
            assign abc_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate
    logic               d_q, d_d, e_q, e_d, rise_q, rise_d;
    logic [COUNT_W-1:0] count_q, count_d;
    always_comb begin
        d_d     = abc_s[2] & abc_s[1];
        // E is derived from D so it can never be 1 while D is 0
        e_d     = d_d & abc_s[0];
        rise_d  = e_d & ~e_q;
        count_d = (rise_q && !(&count_q)) ? count_q + COUNT_W'(1) : count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q     <= 1'b0;
            e_q     <= 1'b0;
            rise_q  <= 1'b0;
            count_q <= '0;
        end else begin
            d_q     <= d_d;
            e_q     <= e_d;
            rise_q  <= rise_d;
            count_q <= count_d;
        end
    end
    assign D       = d_q;
    assign E       = e_q;
    assign e_rise  = rise_q;
    assign e_count = count_q;
endmodule

// File: tb/tb_three_input_and_gate_b.sv
// tb_three_input_and_gate_b: randomized and directed checks of two builds against an edge-history reference model
module tb_three_input_and_gate_b;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       A = 1'b0, B = 1'b0, C = 1'b0;
    logic       d0, e0, r0, d1, e1, r1;
    logic [7:0] c0;
    logic [1:0] c1;
    int         n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;
    three_input_and_gate_b #(.SYNC_STAGES(2), .COUNT_W(8)) u_def (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
        .D(d0), .E(e0), .e_rise(r0), .e_count(c0)
    );
    three_input_and_gate_b #(.SYNC_STAGES(0), .COUNT_W(2)) u_s0 (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
        .D(d1), .E(e1), .e_rise(r1), .e_count(c1)
    );
    // reference: every edge's input sample is logged; logic at edge k sees the
    // sample from edge k-S unless a reset edge occurred since then
    localparam int SS [2] = '{2, 0};
    localparam int CW [2] = '{8, 2};
    logic [2:0] samples [4096];
    int         edge_n = 0, last_rst = -1;
    int         ed [2] = '{0, 0}, ee [2] = '{0, 0}, er [2] = '{0, 0}, ec [2] = '{0, 0};
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    endtask
    task automatic model();
        int k, src, mx;
        logic [2:0] v;
        k = edge_n;
        edge_n++;
        samples[k] = {A, B, C};
        if (rst) last_rst = k;
        for (int i = 0; i < 2; i++) begin
            src = k - SS[i];
            mx  = (1 << CW[i]) - 1;
            if (rst) begin
                ed[i] = 0; ee[i] = 0; er[i] = 0; ec[i] = 0;
            end else begin
                v     = (src > last_rst) ? samples[src] : 3'b000;
                ec[i] = (ec[i] + er[i] > mx) ? mx : ec[i] + er[i];
                er[i] = (v == 3'b111 && ee[i] == 0) ? 1 : 0;
                ed[i] = (v[2] & v[1]) ? 1 : 0;
                ee[i] = (v == 3'b111) ? 1 : 0;
            end
        end
    endtask
    task automatic tick();
        @(posedge clk);
        model();
        #1;
        check("d_def", int'(d0), ed[0]);
        check("e_def", int'(e0), ee[0]);
        check("rise_def", int'(r0), er[0]);
        check("count_def", int'(c0), ec[0]);
        check("d_s0", int'(d1), ed[1]);
        check("e_s0", int'(e1), ee[1]);
        check("rise_s0", int'(r1), er[1]);
        check("count_s0", int'(c1), ec[1]);
        check("e_sub_d_def", int'(e0 & ~d0), 0);
        check("e_sub_d_s0", int'(e1 & ~d1), 0);
    endtask
    task automatic run(input logic [2:0] abc, input logic r, input int n);
        {A, B, C} = abc;
        rst = r;
        for (int i = 0; i < n; i++) tick();
    endtask
    initial begin
        run(3'b111, 1'b1, 4);
        check("rst_count_def", int'(c0), 0);
        run(3'b111, 1'b0, 3);
        check("release_e_def", int'(e0), 1);
        check("release_rise_def", int'(r0), 1);
        tick();
        check("release_count_def", int'(c0), 1);
        run(3'b111, 1'b0, 4);
        for (int v = 0; v < 8; v++) run(3'(v), 1'b0, 10);
        run(3'b000, 1'b1, 1);
        for (int t = 0; t < 200; t++) begin
            A = ((t / 10) % 2) == 1;
            B = ((t / 7) % 2) == 1;
            C = ((t / 5) % 2) == 1;
            tick();
        end
        run(3'b000, 1'b1, 1);
        run(3'b110, 1'b0, 4);
        for (int p = 0; p < 6; p++) begin
            run(3'b111, 1'b0, 3);
            run(3'b110, 1'b0, 3);
        end
        check("sat_count_s0", int'(c1), 3);
        check("sat_count_def", int'(c0), 6);
        run(3'b000, 1'b1, 2);
        run(3'b000, 1'b0, 4);
        run(3'b111, 1'b0, 2);
        run(3'b111, 1'b1, 1);
        run(3'b111, 1'b0, 8);
        check("midrst_count_def", int'(c0), 1);
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 2) == 0) A = ~A;
            if ($urandom_range(0, 2) == 0) B = ~B;
            if ($urandom_range(0, 2) == 0) C = ~C;
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
